// File: rtl/eth_rx_link_mux.sv
// Forwards the RX frame stream of either the 10G or the 1G link to one output stream.
// Preference for 10G is re-evaluated only between frames.
module eth_rx_link_mux #(
    parameter int CTR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baser_up,
    input  logic                 baset_up,
    input  logic                 r_start,
    input  logic                 r_data_valid,
    input  logic [2:0]           r_bytes_valid,
    input  logic [31:0]          r_data,
    input  logic                 r_commit,
    input  logic                 r_drop,
    input  logic                 t_start,
    input  logic                 t_data_valid,
    input  logic [2:0]           t_bytes_valid,
    input  logic [31:0]          t_data,
    input  logic                 t_commit,
    input  logic                 t_drop,
    output logic                 out_start,
    output logic                 out_data_valid,
    output logic [2:0]           out_bytes_valid,
    output logic [31:0]          out_data,
    output logic                 out_commit,
    output logic                 out_drop,
    output logic [1:0]           link_sel,
    output logic [CTR_WIDTH-1:0] frames_fwd,
    output logic [CTR_WIDTH-1:0] frames_abort
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FRAME_R = 2'd1,
        FRAME_T = 2'd2
    } state_t;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_1G   = 2'b01;
    localparam logic [1:0] SEL_10G  = 2'b10;

    localparam logic [CTR_WIDTH-1:0] CTR_MAX = {CTR_WIDTH{1'b1}};
    localparam logic [CTR_WIDTH-1:0] CTR_ONE = {{(CTR_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [1:0]             link_sel_q, link_sel_d;
    logic                   out_start_q, out_start_d;
    logic                   out_data_valid_q, out_data_valid_d;
    logic [2:0]             out_bytes_valid_q, out_bytes_valid_d;
    logic [31:0]            out_data_q, out_data_d;
    logic                   out_commit_q, out_commit_d;
    logic                   out_drop_q, out_drop_d;
    logic [CTR_WIDTH-1:0]   frames_fwd_q, frames_fwd_d;
    logic [CTR_WIDTH-1:0]   frames_abort_q, frames_abort_d;

    logic [1:0]             sel;
    logic                   f_start;
    logic                   f_data_valid;
    logic [2:0]             f_bytes_valid;
    logic [31:0]            f_data;
    logic                   f_commit;
    logic                   f_drop;
    logic                   f_up;
    logic                   inc_fwd;
    logic                   inc_abort;

    always_comb begin
        if (baser_up) begin
            sel = SEL_10G;
        end else if (baset_up) begin
            sel = SEL_1G;
        end else begin
            sel = SEL_NONE;
        end
    end

    // View of whichever link owns the frame in progress.
    always_comb begin
        f_start       = r_start;
        f_data_valid  = r_data_valid;
        f_bytes_valid = r_bytes_valid;
        f_data        = r_data;
        f_commit      = r_commit;
        f_drop        = r_drop;
        f_up          = baser_up;
        if (state_q == FRAME_T) begin
            f_start       = t_start;
            f_data_valid  = t_data_valid;
            f_bytes_valid = t_bytes_valid;
            f_data        = t_data;
            f_commit      = t_commit;
            f_drop        = t_drop;
            f_up          = baset_up;
        end
    end

    always_comb begin
        state_d           = state_q;
        link_sel_d        = link_sel_q;
        out_start_d       = 1'b0;
        out_data_valid_d  = 1'b0;
        out_bytes_valid_d = 3'd0;
        out_data_d        = 32'd0;
        out_commit_d      = 1'b0;
        out_drop_d        = 1'b0;
        inc_fwd           = 1'b0;
        inc_abort         = 1'b0;

        case (state_q)
            IDLE: begin
                link_sel_d = sel;
                if (sel == SEL_10G && r_start) begin
                    state_d     = FRAME_R;
                    out_start_d = 1'b1;
                end else if (sel == SEL_1G && t_start) begin
                    state_d     = FRAME_T;
                    out_start_d = 1'b1;
                end
            end
            FRAME_R, FRAME_T: begin
                // Drop and a repeated start beat commit; commit beats link loss.
                if (f_drop || f_start) begin
                    out_drop_d = 1'b1;
                    inc_abort  = 1'b1;
                    state_d    = IDLE;
                end else if (f_commit) begin
                    out_commit_d = 1'b1;
                    inc_fwd      = 1'b1;
                    state_d      = IDLE;
                end else if (!f_up) begin
                    out_drop_d = 1'b1;
                    inc_abort  = 1'b1;
                    state_d    = IDLE;
                end else if (f_data_valid) begin
                    out_data_valid_d  = 1'b1;
                    out_bytes_valid_d = f_bytes_valid;
                    out_data_d        = f_data;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        frames_fwd_d   = frames_fwd_q;
        frames_abort_d = frames_abort_q;
        if (inc_fwd && frames_fwd_q != CTR_MAX) begin
            frames_fwd_d = frames_fwd_q + CTR_ONE;
        end
        if (inc_abort && frames_abort_q != CTR_MAX) begin
            frames_abort_d = frames_abort_q + CTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= IDLE;
            link_sel_q        <= SEL_NONE;
            out_start_q       <= 1'b0;
            out_data_valid_q  <= 1'b0;
            out_bytes_valid_q <= 3'd0;
            out_data_q        <= 32'd0;
            out_commit_q      <= 1'b0;
            out_drop_q        <= 1'b0;
            frames_fwd_q      <= '0;
            frames_abort_q    <= '0;
        end else begin
            state_q           <= state_d;
            link_sel_q        <= link_sel_d;
            out_start_q       <= out_start_d;
            out_data_valid_q  <= out_data_valid_d;
            out_bytes_valid_q <= out_bytes_valid_d;
            out_data_q        <= out_data_d;
            out_commit_q      <= out_commit_d;
            out_drop_q        <= out_drop_d;
            frames_fwd_q      <= frames_fwd_d;
            frames_abort_q    <= frames_abort_d;
        end
    end

    assign out_start       = out_start_q;
    assign out_data_valid  = out_data_valid_q;
    assign out_bytes_valid = out_bytes_valid_q;
    assign out_data        = out_data_q;
    assign out_commit      = out_commit_q;
    assign out_drop        = out_drop_q;
    assign link_sel        = link_sel_q;
    assign frames_fwd      = frames_fwd_q;
    assign frames_abort    = frames_abort_q;

endmodule
